// File: rtl/bit_scan.sv
// bit_scan: serial population count and lowest-set-bit finder for one 32-bit word.
//
// A word is accepted in IDLE, shifted out LSB-first one bit per clock in SCAN while the
// set bits are counted and the position of the first one is latched, then the result is
// held in DONE until the consumer takes it.
//
// Parameters
//   EARLY_EXIT  0: always 32 scan cycles; 1: stop as soon as no set bits remain.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    in_data is presented
//   in_ready    block can accept a word (IDLE)
//   in_data     32-bit word to scan
//   out_valid   result is valid (DONE)
//   out_ready   consumer takes the result
//   out_count   number of set bits, 0..32
//   out_onehot  exactly one bit set
//   out_zero    no bit set
//   out_index   index of the lowest set bit, 0 when out_zero
module bit_scan #(
  parameter int unsigned EARLY_EXIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_count,
  output logic        out_onehot,
  output logic        out_zero,
  output logic [4:0]  out_index
);

  localparam bit EarlyExit = (EARLY_EXIT != 0);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  count_q, count_d;   // 6 bits so an all-ones word reports 32
  logic [4:0]  index_q, index_d;
  logic        found_q, found_d;   // lowest set bit already latched

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    count_d   = count_q;
    index_d   = index_q;
    found_d   = found_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d   = in_data;
          bit_cnt_d = 5'd0;
          count_d   = 6'd0;
          index_d   = 5'd0;
          found_d   = 1'b0;
          state_d   = StScan;
        end
      end

      StScan: begin
        if (shift_q[0]) begin
          count_d = count_q + 6'd1;
          if (!found_q) begin
            index_d = bit_cnt_q;
            found_d = 1'b1;
          end
        end
        shift_d   = {1'b0, shift_q[31:1]};
        bit_cnt_d = bit_cnt_q + 5'd1;
        // Bit 31 is processed on the final fixed-length edge; early exit looks at the
        // word as it will be after this edge's shift.
        if ((bit_cnt_q == 5'd31) || (EarlyExit && (shift_q[31:1] == 31'd0))) begin
          state_d = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= 32'd0;
      bit_cnt_q <= 5'd0;
      count_q   <= 6'd0;
      index_q   <= 5'd0;
      found_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      count_q   <= count_d;
      index_q   <= index_d;
      found_q   <= found_d;
    end
  end

  // Handshakes are decoded straight from the state register; results come straight from
  // the registered count/index so they stay put through DONE and the following IDLE.
  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_count  = count_q;
  assign out_onehot = (count_q == 6'd1);
  assign out_zero   = (count_q == 6'd0);
  assign out_index  = index_q;

endmodule

// File: tb/tb_bit_scan.sv
// Bench for bit_scan: instance 0 uses the fixed 32-cycle scan, instance 1 early exit.
// Accepted words are turned into expected results by a reference model and queued; a
// monitor process compares every DONE cycle against the queue head and pops on handshake.
module tb_bit_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [31:0] in_data    [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [5:0]  out_count  [2];
  logic        out_onehot [2];
  logic        out_zero   [2];
  logic [4:0]  out_index  [2];

  always #5 clk = ~clk;

  bit_scan #(.EARLY_EXIT(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid[0]),
    .in_ready   (in_ready[0]),
    .in_data    (in_data[0]),
    .out_valid  (out_valid[0]),
    .out_ready  (out_ready[0]),
    .out_count  (out_count[0]),
    .out_onehot (out_onehot[0]),
    .out_zero   (out_zero[0]),
    .out_index  (out_index[0])
  );

  bit_scan #(.EARLY_EXIT(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid[1]),
    .in_ready   (in_ready[1]),
    .in_data    (in_data[1]),
    .out_valid  (out_valid[1]),
    .out_ready  (out_ready[1]),
    .out_count  (out_count[1]),
    .out_onehot (out_onehot[1]),
    .out_zero   (out_zero[1]),
    .out_index  (out_index[1])
  );

  typedef struct {
    logic [5:0] count;
    logic [4:0] index;
    logic       onehot;
    logic       zero;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int acc_cnt[2];
  int last_acc_edge[2];
  int last_pop_edge[2];
  bit rand_bp = 1'b0;
  bit force_ready[2];

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of out_ready: random backpressure or the value the stimulus asks for.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      out_ready[i] = rand_bp ? ($urandom_range(0, 3) != 0) : force_ready[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: counts and positions by walking the bits; latency from the highest one.
  function automatic exp_t model(input logic [31:0] d, input int ee, input int acc);
    exp_t e;
    int   n  = 0;
    int   lo = -1;
    int   hi = -1;
    for (int b = 0; b < 32; b++) begin
      if (d[b]) begin
        n++;
        if (lo < 0) lo = b;
        hi = b;
      end
    end
    e.count   = 6'(n);
    e.index   = (lo < 0) ? 5'd0 : 5'(lo);
    e.onehot  = (n == 1);
    e.zero    = (n == 0);
    e.lat     = (ee != 0) ? ((hi < 0) ? 1 : hi + 1) : 32;
    e.acc_cyc = acc;
    return e;
  endfunction

  function automatic int sb_size(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  // Monitor: posedge half records accepts/handshakes, negedge half compares outputs.
  initial begin
    bit   seen[2];
    bit   popped[2];
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        sb0.delete();
        sb1.delete();
        seen   = '{0, 0};
        popped = '{0, 0};
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (in_valid[i] && in_ready[i]) begin
            e = model(in_data[i], i, cyc + 1);
            if (i == 0) sb0.push_back(e);
            else        sb1.push_back(e);
            acc_cnt[i]++;
            last_acc_edge[i] = cyc;
          end
          if (out_valid[i] && out_ready[i]) begin
            if (i == 0 && sb0.size() != 0) void'(sb0.pop_front());
            if (i == 1 && sb1.size() != 0) void'(sb1.pop_front());
            seen[i]          = 1'b0;
            popped[i]        = 1'b1;
            last_pop_edge[i] = cyc;
          end
        end
      end
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (popped[i]) begin
            chk($sformatf("idle_after_pop%0d", i), {62'd0, out_valid[i], in_ready[i]}, 64'd1);
            popped[i] = 1'b0;
          end
          if (out_valid[i]) begin
            chk($sformatf("ready_low_in_done%0d", i), 64'(in_ready[i]), 64'd0);
            if (sb_size(i) == 0) begin
              chk($sformatf("spurious_out_valid%0d", i), 64'(out_valid[i]), 64'd0);
            end else begin
              e = (i == 0) ? sb0[0] : sb1[0];
              if (!seen[i]) begin
                chk($sformatf("latency%0d", i), 64'(cyc - e.acc_cyc), 64'(e.lat));
                seen[i] = 1'b1;
              end
              chk($sformatf("count%0d", i), 64'(out_count[i]), 64'(e.count));
              chk($sformatf("index%0d", i), 64'(out_index[i]), 64'(e.index));
              chk($sformatf("onehot%0d", i), 64'(out_onehot[i]), 64'(e.onehot));
              chk($sformatf("zero%0d", i), 64'(out_zero[i]), 64'(e.zero));
            end
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge, with in_data
  // scribbled so a design that rereads it during SCAN is caught.
  task automatic send(input int i, input logic [31:0] d);
    int start = acc_cnt[i];
    int n = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    while (acc_cnt[i] == start && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_timeout%0d", i), 64'(acc_cnt[i] != start), 64'd1);
    in_valid[i] = 1'b0;
    in_data[i]  = $urandom;
  endtask

  task automatic drain(input int i);
    int n = 0;
    while ((sb_size(i) != 0 || !in_ready[i]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain_timeout%0d", i), 64'(sb_size(i) == 0 && in_ready[i]), 64'd1);
  endtask

  task automatic random_words(input int i, input int num);
    logic [31:0] d;
    for (int k = 0; k < num; k++) begin
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = $urandom >> $urandom_range(0, 31);
        2:       d = 32'd1 << $urandom_range(0, 31);
        default: d = 32'd0;
      endcase
      send(i, d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(i);
  endtask

  task automatic chk_reset_outputs(input int i);
    chk($sformatf("rst_in_ready%0d", i), 64'(in_ready[i]), 64'd1);
    chk($sformatf("rst_out_valid%0d", i), 64'(out_valid[i]), 64'd0);
    chk($sformatf("rst_count%0d", i), 64'(out_count[i]), 64'd0);
    chk($sformatf("rst_zero%0d", i), 64'(out_zero[i]), 64'd1);
    chk($sformatf("rst_onehot%0d", i), 64'(out_onehot[i]), 64'd0);
    chk($sformatf("rst_index%0d", i), 64'(out_index[i]), 64'd0);
  endtask

  initial begin
    int n;
    int rel_edge;
    int start;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]    = 1'b0;
      in_data[i]     = 32'd0;
      force_ready[i] = 1'b1;
    end
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner words.
    send(0, 32'h0000_0400); drain(0);
    send(0, 32'hFFFF_FFFF); drain(0);
    send(0, 32'h8000_0000); drain(0);
    send(1, 32'h0000_0000); drain(1);
    send(1, 32'h0000_0006); drain(1);
    send(1, 32'h8000_0001); drain(1);

    // Backpressure with a second word already waiting.
    force_ready[0] = 1'b0;
    send(0, 32'h1234_5678);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h0000_00F0;
    n = 0;
    while (!out_valid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wait_done", 64'(out_valid[0]), 64'd1);
    start = acc_cnt[0];
    repeat (10) @(negedge clk);
    chk("bp_no_accept_in_done", 64'(acc_cnt[0]), 64'(start));
    force_ready[0] = 1'b1;
    n = 0;
    while (acc_cnt[0] == start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_accept_after_idle", 64'(last_acc_edge[0] - last_pop_edge[0]), 64'd1);
    in_valid[0] = 1'b0;
    drain(0);

    // Reset at cycle 15 of a scan; the aborted word must never surface.
    send(0, 32'hA5A5_A5A5);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h0000_0003;
    repeat (2) @(negedge clk);
    start    = acc_cnt[0];
    rel_edge = cyc;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("accept_first_edge", 64'(acc_cnt[0] - start), 64'd1);
    chk("accept_first_edge_cyc", 64'(last_acc_edge[0]), 64'(rel_edge));
    in_valid[0] = 1'b0;
    drain(0);

    // Random traffic on both instances with random backpressure.
    rand_bp = 1'b1;
    fork
      random_words(0, 15);
      random_words(1, 25);
    join
    rand_bp = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bit_scan.md
BIT_SCAN -- requirements
Module: bit_scan

Interface
REQ-001 SHALL have parameter EARLY_EXIT, default 0: 0 = fixed 32-cycle scan, 1 = scan ends once no set bits remain.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_data is presented.
REQ-005 SHALL have port in_ready  output  1  block can accept a word.
REQ-006 SHALL have port in_data  input  32  word to scan; all 32 bits are significant.
REQ-007 SHALL have port out_valid  output  1  result is valid.
REQ-008 SHALL have port out_ready  input  1  consumer takes the result.
REQ-009 SHALL have port out_count  output  6  number of set bits, 0..32.
REQ-010 SHALL have port out_onehot  output  1  exactly one bit set.
REQ-011 SHALL have port out_zero  output  1  no bit set.
REQ-012 SHALL have port out_index  output  5  index of the lowest set bit; 0 when out_zero.

Function
REQ-013 SHALL implement the states IDLE, SCAN and DONE, held in a state register.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE, both decoded directly from the state register.
REQ-015 SHALL accept a word on the edge where in_valid&&in_ready, and on that edge SHALL:
- load a 32-bit shift register with in_data;
- clear the bit counter (5 bits), count accumulator and index register;
- clear the first-set-found flag;
- go to SCAN.
REQ-016 SHALL, on each SCAN edge:
- examine shift[0]; if 1, increment count;
- if 1 and the first-set flag is clear, load index with the bit counter and set the flag;
- then shift right by one and increment the bit counter.
REQ-017 SHALL leave SCAN for DONE on the edge that processes bit counter 31, giving 32 cycles from the accept edge to out_valid.
REQ-018 SHALL, when EARLY_EXIT=1, also go to DONE on the edge where the post-shift register is all zeros; latency is (highest set bit index + 1) cycles, and 1 cycle for in_data=0.
REQ-019 SHALL size count to 6 bits so that 32 set bits reports 32 without wrap.
REQ-020 SHALL derive out_onehot = (count==1) and out_zero = (count==0) from the registered count, without extra latency.
REQ-021 SHALL hold all result outputs stable while in DONE until out_ready=1.
REQ-022 SHALL go DONE->IDLE on the edge where out_valid&&out_ready.
REQ-023 SHALL NOT accept a new word on the same edge as REQ-022, because in_ready is 0 in DONE; the earliest next accept is the following edge.
REQ-024 SHALL ignore in_valid and in_data while in SCAN or DONE; the word in the shift register is never disturbed.
REQ-025 SHALL keep out_count/out_onehot/out_zero/out_index at their last result in IDLE until the next accept edge clears them.
REQ-026 SHALL ignore out_ready when out_valid=0.

Reset
REQ-027 SHALL, while rst_n=0, immediately force:
- state=IDLE, in_ready=1, out_valid=0;
- out_count=0, out_zero=1, out_onehot=0, out_index=0;
- shift register, bit counter and first-set flag = 0.
REQ-028 SHALL abort any in-progress scan on reset assertion mid-SCAN or mid-DONE, discard that result, and never emit it after reset release.
REQ-029 SHALL permit an accept on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL cover: EARLY_EXIT=0, in_data=0x00000400 -> out_valid exactly 32 cycles after accept; count=1, onehot=1, zero=0, index=10.
REQ-031 SHALL cover: EARLY_EXIT=0, in_data=0xFFFFFFFF -> count=32, onehot=0, zero=0, index=0; also in_data=0x80000000 -> count=1, onehot=1, index=31 (bit 31 counted).
REQ-032 SHALL cover: EARLY_EXIT=1, in_data=0 -> out_valid 1 cycle after accept, count=0, zero=1, index=0; in_data=0x00000006 -> out_valid 3 cycles after accept, count=2, index=1.
REQ-033 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable; then out_ready=1 -> IDLE next edge. A new in_valid held high throughout -> accepted no earlier than the edge after return to IDLE. A new in_data driven during SCAN -> result unaffected.
REQ-034 SHALL cover reset mid-scan: rst_n low at cycle 15 of a scan -> outputs at reset values asynchronously; after release, no out_valid until a new word completes.
